sdram_apb_boot_cfg: RTL and testbench
=====================================

// Module: sdram_apb_boot_cfg
// PURPOSE
//  APB master/arbiter sitting directly upstream of the SDRAM controller CSR APB port.
//  After PRESETn negates, it autonomously writes TIMING (0x4) and TREF (0x8),
//  polls CTRL (0x0) bit30 (init_done), then writes CTRL (bit31 = enable).
//  It then hands the CSR APB port to the system APB slave port as a transparent pass-through.
// PARAMETERS
//  BOOT_EN      1        0: start in DONE; pure pass-through
//  BOOT_TIMING  32'h0    value written to TIMING
//  BOOT_TREF    16'd128  value written to TREF[15:0]; upper 16 bits written as 0
//  BOOT_CTRL    32'h0    value written to CTRL; bit30 is ignored, bit31 is forced to 1
//  POLL_MAX     4096     maximum CTRL reads before timeout
//  PADDR_SIZE   4        APB address width
//  PDATA_SIZE   32       APB data width
// PORTS
//  PCLK        in   1    APB clock
//  PRESETn     in   1    asynchronous, active-low reset
//  s_PSEL,s_PENABLE,s_PWRITE  in  1    upstream APB slave control
//  s_PADDR     in   PADDR_SIZE    upstream address
//  s_PWDATA    in   PDATA_SIZE    upstream write data
//  s_PSTRB     in   PDATA_SIZE/8  upstream byte strobes
//  s_PPROT     in   3             upstream protection
//  s_PRDATA    out  PDATA_SIZE    upstream read data
//  s_PREADY,s_PSLVERR  out  1     upstream response
//  m_PSEL,m_PENABLE,m_PWRITE  out  1   to CSR block
//  m_PADDR     out  PADDR_SIZE    to CSR block
//  m_PWDATA    out  PDATA_SIZE    to CSR block
//  m_PSTRB     out  PDATA_SIZE/8  to CSR block
//  m_PPROT     out  3             to CSR block
//  m_PRDATA    in   PDATA_SIZE    from CSR block
//  m_PREADY,m_PSLVERR  in  1      from CSR block
//  boot_done_o out  1   boot sequence completed successfully; sticky until reset
//  boot_err_o  out  1   PSLVERR or poll timeout during boot; sticky until reset
// BEHAVIOUR
//  Reset values: m_PSEL=0, m_PENABLE=0, boot_done_o=0, boot_err_o=0, step=0, poll_cnt=0.
//  FSM states: SETUP, ACCESS, HANDOVER, DONE. Reset state is SETUP when BOOT_EN=1, else DONE.
//  step 0..3 selects the transfer:
//    0: WR 0x4 = BOOT_TIMING
//    1: WR 0x8 = {16'h0, BOOT_TREF}
//    2: RD 0x0 (poll)
//    3: WR 0x0 = BOOT_CTRL | 1<<31
//  Boot transfers always use PSTRB='1 and PPROT=3'b001 (privileged, so the PP bit cannot block).
//  SETUP: m_PSEL=1, m_PENABLE=0 for one cycle, then go to ACCESS.
//  ACCESS: m_PSEL=1, m_PENABLE=1; hold until m_PREADY=1 (wait states are unbounded).
//  On completion in ACCESS:
//    - m_PSLVERR=1: boot_err_o<=1, go to HANDOVER.
//    - step 2 with PRDATA[30]=0: poll_cnt++, back to SETUP with step 2; poll_cnt==POLL_MAX-1 gives err.
//    - step 3: boot_done_o<=1, go to HANDOVER.
//    - otherwise: step++, go to SETUP.
//  m_* signals are registered during boot. m_PSEL drops for 0 cycles between steps
//  (back-to-back SETUP is legal APB).
//  During SETUP/ACCESS: s_PREADY=0, s_PSLVERR=0, s_PRDATA=0. Upstream transfers stall and none are lost.
//  HANDOVER (1 cycle):
//    - m_PENABLE=0; m_PSEL, m_PADDR, m_PWRITE, m_PWDATA, m_PSTRB, m_PPROT = s_*; s_PREADY=0.
//    - This gives a pending upstream access a proper setup phase at the CSR block.
//    - Without it, a stalled write would bypass the CSR block's PREADY CDC stretch.
//  DONE: combinational pass-through m_*=s_*, s_PRDATA/s_PREADY/s_PSLVERR=m_*; adds zero latency.
//  Simultaneous events:
//    - PSLVERR together with PREADY=0 is ignored; the response is sampled only with PREADY=1.
//    - Error at step 3 sets err only; done stays 0.
//  Reset mid-operation: PRESETn low aborts immediately, m_PSEL=0 asynchronously, and the sequence restarts.
//  poll_cnt width is $clog2(POLL_MAX+1) and saturates; it is not wrap-safe beyond POLL_MAX.
// STRUCTURE
//  Single module; no sub-module required.
//  The state enum boot_state_t and localparams CSR_CTRL/CSR_TIME/CSR_TREF (0x0/0x4/0x8)
//  are moved into sdram_ctrl_pkg and shared with the CSR APB interface.
//  CTRL bit indices EN=31 and INIT_DONE=30 are also package localparams.
// TESTING
//  1 BOOT_TIMING=32'h1234_5678, BOOT_TREF=200, CSR INIT_DLY_CNT=20:
//    -> writes 0x4, 0x8 seen in order; CTRL polled until bit30=1;
//    -> CTRL written with bit31=1; boot_done_o=1.
//  2 Upstream write 0x4=32'hA5A5 issued at reset+1:
//    -> s_PREADY held 0 through boot; HANDOVER produces m_PENABLE=0 then 1.
//    -> CSR TIMING reads back 32'hA5A5.
//  3 Slave returns PSLVERR on step 1:
//    -> boot_err_o=1, boot_done_o=0; step 2/3 never issued; pass-through active next-next cycle.
//  4 init_done never rises, POLL_MAX=8:
//    -> exactly 8 reads to 0x0, then boot_err_o=1; CTRL never written.
//  5 PRESETn pulsed low during step 2 ACCESS:
//    -> m_PSEL=0 immediately; after release, sequence restarts at step 0 and completes.
//  6 BOOT_EN=0:
//    -> m_*==s_* from the first cycle; random APB reads/writes match a direct connection cycle-for-cycle.

Source files
------------

// File: rtl/sdram_ctrl_pkg.sv
// Shared CSR map, CTRL bit positions and boot FSM types for the SDRAM controller APB path.
// Also holds the step-to-transfer table for the boot sequencer.
package sdram_ctrl_pkg;

    typedef enum logic [1:0] {
        SETUP    = 2'd0,
        ACCESS   = 2'd1,
        HANDOVER = 2'd2,
        DONE     = 2'd3
    } boot_state_t;

    localparam logic [31:0] CSR_CTRL = 32'h0;
    localparam logic [31:0] CSR_TIME = 32'h4;
    localparam logic [31:0] CSR_TREF = 32'h8;

    localparam int CTRL_EN        = 31;
    localparam int CTRL_INIT_DONE = 30;

    // Privileged so the CSR block's protection check can never reject a boot access.
    localparam logic [2:0] BOOT_PPROT = 3'b001;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } boot_xfer_t;

    function automatic boot_xfer_t boot_xfer(input logic [1:0]  step,
                                             input logic [31:0] timing,
                                             input logic [31:0] tref,
                                             input logic [31:0] ctrl);
        boot_xfer_t x;
        x.write = 1'b1;
        x.addr  = CSR_TIME;
        x.wdata = timing;
        case (step)
            2'd1: begin
                x.addr  = CSR_TREF;
                x.wdata = tref;
            end
            2'd2: begin
                x.write = 1'b0;
                x.addr  = CSR_CTRL;
                x.wdata = '0;
            end
            2'd3: begin
                x.addr  = CSR_CTRL;
                x.wdata = ctrl;
            end
            default: ;
        endcase
        return x;
    endfunction

endpackage

// File: rtl/sdram_apb_boot_cfg.sv
// APB boot sequencer/arbiter in front of the SDRAM CSR port: programs TIMING/TREF, polls init_done, enables CTRL.
// Registered m_* during boot, zero-latency pass-through afterwards; upstream is stalled (PREADY=0) until handover.
module sdram_apb_boot_cfg
    import sdram_ctrl_pkg::*;
#(
    parameter bit          BOOT_EN     = 1'b1,
    parameter logic [31:0] BOOT_TIMING = 32'h0,
    parameter logic [15:0] BOOT_TREF   = 16'd128,
    parameter logic [31:0] BOOT_CTRL   = 32'h0,
    parameter int          POLL_MAX    = 4096,
    parameter int          PADDR_SIZE  = 4,
    parameter int          PDATA_SIZE  = 32
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,

    input  logic                    s_PSEL,
    input  logic                    s_PENABLE,
    input  logic                    s_PWRITE,
    input  logic [PADDR_SIZE-1:0]   s_PADDR,
    input  logic [PDATA_SIZE-1:0]   s_PWDATA,
    input  logic [PDATA_SIZE/8-1:0] s_PSTRB,
    input  logic [2:0]              s_PPROT,
    output logic [PDATA_SIZE-1:0]   s_PRDATA,
    output logic                    s_PREADY,
    output logic                    s_PSLVERR,

    output logic                    m_PSEL,
    output logic                    m_PENABLE,
    output logic                    m_PWRITE,
    output logic [PADDR_SIZE-1:0]   m_PADDR,
    output logic [PDATA_SIZE-1:0]   m_PWDATA,
    output logic [PDATA_SIZE/8-1:0] m_PSTRB,
    output logic [2:0]              m_PPROT,
    input  logic [PDATA_SIZE-1:0]   m_PRDATA,
    input  logic                    m_PREADY,
    input  logic                    m_PSLVERR,

    output logic                    boot_done_o,
    output logic                    boot_err_o
);

    localparam int PW = $clog2(POLL_MAX + 1);

    localparam logic [31:0] TREF_WORD = {16'h0, BOOT_TREF};
    localparam logic [31:0] CTRL_WORD = BOOT_CTRL | (32'h1 << CTRL_EN);

    boot_state_t           state_q, state_d;
    logic [1:0]            step_q, step_d;
    logic [PW-1:0]         poll_cnt_q, poll_cnt_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  m_psel_q, m_penable_q, m_pwrite_q;
    logic [PADDR_SIZE-1:0] m_paddr_q;
    logic [PDATA_SIZE-1:0] m_pwdata_q;
    boot_xfer_t            xfer_d;

    // Boot bus outputs are registered from the next state, so SETUP only
    // advances once m_PSEL has really been presented for a cycle.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= BOOT_EN ? SETUP : DONE;
            step_q      <= 2'd0;
            poll_cnt_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            m_psel_q    <= 1'b0;
            m_penable_q <= 1'b0;
            m_pwrite_q  <= 1'b0;
            m_paddr_q   <= '0;
            m_pwdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            poll_cnt_q  <= poll_cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            m_psel_q    <= (state_d == SETUP) || (state_d == ACCESS);
            m_penable_q <= (state_d == ACCESS);
            m_pwrite_q  <= xfer_d.write;
            m_paddr_q   <= PADDR_SIZE'(xfer_d.addr);
            m_pwdata_q  <= PDATA_SIZE'(xfer_d.wdata);
        end
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        poll_cnt_d = poll_cnt_q;
        done_d     = done_q;
        err_d      = err_q;
        case (state_q)
            SETUP: begin
                if (m_psel_q) state_d = ACCESS;
            end
            ACCESS: begin
                if (m_PREADY) begin
                    if (m_PSLVERR) begin
                        err_d   = 1'b1;
                        state_d = HANDOVER;
                    end else if (step_q == 2'd2 && !m_PRDATA[CTRL_INIT_DONE]) begin
                        if (poll_cnt_q == PW'(POLL_MAX - 1)) begin
                            err_d   = 1'b1;
                            state_d = HANDOVER;
                        end else begin
                            if (poll_cnt_q < PW'(POLL_MAX)) poll_cnt_d = poll_cnt_q + 1'b1;
                            state_d = SETUP;
                        end
                    end else if (step_q == 2'd3) begin
                        done_d  = 1'b1;
                        state_d = HANDOVER;
                    end else begin
                        step_d  = step_q + 2'd1;
                        state_d = SETUP;
                    end
                end
            end
            HANDOVER: state_d = DONE;
            DONE:     state_d = DONE;
            default:  state_d = state_q;
        endcase
        xfer_d = boot_xfer(step_d, BOOT_TIMING, TREF_WORD, CTRL_WORD);
    end

    // HANDOVER gives any stalled upstream access a fresh setup phase at the CSR block.
    always_comb begin
        m_PSEL    = m_psel_q;
        m_PENABLE = m_penable_q;
        m_PWRITE  = m_pwrite_q;
        m_PADDR   = m_paddr_q;
        m_PWDATA  = m_pwdata_q;
        m_PSTRB   = '1;
        m_PPROT   = BOOT_PPROT;
        s_PRDATA  = '0;
        s_PREADY  = 1'b0;
        s_PSLVERR = 1'b0;
        case (state_q)
            HANDOVER: begin
                m_PSEL    = s_PSEL;
                m_PENABLE = 1'b0;
                m_PWRITE  = s_PWRITE;
                m_PADDR   = s_PADDR;
                m_PWDATA  = s_PWDATA;
                m_PSTRB   = s_PSTRB;
                m_PPROT   = s_PPROT;
            end
            DONE: begin
                m_PSEL    = s_PSEL;
                m_PENABLE = s_PENABLE;
                m_PWRITE  = s_PWRITE;
                m_PADDR   = s_PADDR;
                m_PWDATA  = s_PWDATA;
                m_PSTRB   = s_PSTRB;
                m_PPROT   = s_PPROT;
                s_PRDATA  = m_PRDATA;
                s_PREADY  = m_PREADY;
                s_PSLVERR = m_PSLVERR;
            end
            default: ;
        endcase
    end

    assign boot_done_o = done_q;
    assign boot_err_o  = err_q;

endmodule

// File: tb/tb_sdram_apb_boot_cfg.sv
// Directed bench: boot sequencer against a small CSR slave model, plus a BOOT_EN=0 pass-through instance.
module tb_sdram_apb_boot_cfg;

    logic PCLK = 1'b0;
    logic PRESETn = 1'b0;
    always #5 PCLK = ~PCLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Boot instance, upstream side
    logic        s_psel = 0, s_penable = 0, s_pwrite = 0;
    logic [3:0]  s_paddr = 0;
    logic [31:0] s_pwdata = 0;
    logic [3:0]  s_pstrb = 0;
    logic [2:0]  s_pprot = 0;
    logic [31:0] s_prdata;
    logic        s_pready, s_pslverr;
    // Boot instance, CSR side
    logic        m_psel, m_penable, m_pwrite;
    logic [3:0]  m_paddr;
    logic [31:0] m_pwdata;
    logic [3:0]  m_pstrb;
    logic [2:0]  m_pprot;
    logic [31:0] m_prdata;
    logic        m_pready, m_pslverr;
    logic        boot_done, boot_err;

    sdram_apb_boot_cfg #(
        .BOOT_EN(1'b1), .BOOT_TIMING(32'h1234_5678), .BOOT_TREF(16'd200),
        .BOOT_CTRL(32'h0000_0011), .POLL_MAX(8), .PADDR_SIZE(4), .PDATA_SIZE(32)
    ) u_dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .s_PSEL(s_psel), .s_PENABLE(s_penable), .s_PWRITE(s_pwrite), .s_PADDR(s_paddr),
        .s_PWDATA(s_pwdata), .s_PSTRB(s_pstrb), .s_PPROT(s_pprot),
        .s_PRDATA(s_prdata), .s_PREADY(s_pready), .s_PSLVERR(s_pslverr),
        .m_PSEL(m_psel), .m_PENABLE(m_penable), .m_PWRITE(m_pwrite), .m_PADDR(m_paddr),
        .m_PWDATA(m_pwdata), .m_PSTRB(m_pstrb), .m_PPROT(m_pprot),
        .m_PRDATA(m_prdata), .m_PREADY(m_pready), .m_PSLVERR(m_pslverr),
        .boot_done_o(boot_done), .boot_err_o(boot_err)
    );

    // Pass-through instance
    logic        p_s_psel = 0, p_s_penable = 0, p_s_pwrite = 0;
    logic [3:0]  p_s_paddr = 0;
    logic [31:0] p_s_pwdata = 0;
    logic [3:0]  p_s_pstrb = 0;
    logic [2:0]  p_s_pprot = 0;
    logic [31:0] p_s_prdata;
    logic        p_s_pready, p_s_pslverr;
    logic        p_m_psel, p_m_penable, p_m_pwrite;
    logic [3:0]  p_m_paddr;
    logic [31:0] p_m_pwdata;
    logic [3:0]  p_m_pstrb;
    logic [2:0]  p_m_pprot;
    logic [31:0] p_m_prdata = 0;
    logic        p_m_pready = 0, p_m_pslverr = 0;
    logic        p_done, p_err;

    sdram_apb_boot_cfg #(
        .BOOT_EN(1'b0), .BOOT_TIMING(32'h0), .BOOT_TREF(16'd128),
        .BOOT_CTRL(32'h0), .POLL_MAX(4096), .PADDR_SIZE(4), .PDATA_SIZE(32)
    ) u_dut_pt (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .s_PSEL(p_s_psel), .s_PENABLE(p_s_penable), .s_PWRITE(p_s_pwrite), .s_PADDR(p_s_paddr),
        .s_PWDATA(p_s_pwdata), .s_PSTRB(p_s_pstrb), .s_PPROT(p_s_pprot),
        .s_PRDATA(p_s_prdata), .s_PREADY(p_s_pready), .s_PSLVERR(p_s_pslverr),
        .m_PSEL(p_m_psel), .m_PENABLE(p_m_penable), .m_PWRITE(p_m_pwrite), .m_PADDR(p_m_paddr),
        .m_PWDATA(p_m_pwdata), .m_PSTRB(p_m_pstrb), .m_PPROT(p_m_pprot),
        .m_PRDATA(p_m_prdata), .m_PREADY(p_m_pready), .m_PSLVERR(p_m_pslverr),
        .boot_done_o(p_done), .boot_err_o(p_err)
    );

    // CSR slave model: wait states, delayed init_done, error injection, transfer log
    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] dat;
        logic [3:0]  strb;
        logic [2:0]  prot;
    } xact_t;
    xact_t log_q[$];

    int          ws = 1, wcnt, cyc, init_dly = 12;
    bit          junk_err = 1'b1, err_en = 1'b0;
    logic [3:0]  err_addr = 4'h8;
    logic [31:0] csr_timing, csr_tref, csr_ctrl;
    logic        acc, init_done;

    assign acc       = m_psel & m_penable;
    assign init_done = (cyc >= init_dly);
    assign m_pready  = acc && (wcnt >= ws);
    assign m_pslverr = acc && (m_pready ? (err_en && m_pwrite && m_paddr == err_addr) : junk_err);

    always_comb begin
        m_prdata = 32'h0;
        case (m_paddr)
            4'h0: m_prdata = {csr_ctrl[31], init_done, csr_ctrl[29:0]};
            4'h4: m_prdata = csr_timing;
            4'h8: m_prdata = csr_tref;
            default: m_prdata = 32'h0;
        endcase
    end

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wcnt <= 0; cyc <= 0;
            csr_timing <= 0; csr_tref <= 0; csr_ctrl <= 0;
        end else begin
            cyc <= cyc + 1;
            if (acc && !m_pready) wcnt <= wcnt + 1;
            else wcnt <= 0;
            if (acc && m_pready) begin
                log_q.push_back('{m_pwrite, m_paddr, (m_pwrite ? m_pwdata : m_prdata), m_pstrb, m_pprot});
                if (m_pwrite && !m_pslverr) begin
                    case (m_paddr)
                        4'h0: csr_ctrl   <= m_pwdata;
                        4'h4: csr_timing <= m_pwdata;
                        4'h8: csr_tref   <= {16'h0, m_pwdata[15:0]};
                        default: ;
                    endcase
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic xact_t log_at(input int k);
        xact_t z = '{1'b0, 4'h0, 32'h0, 4'h0, 3'h0};
        if (k >= 0 && k < log_q.size()) z = log_q[k];
        return z;
    endfunction

    task automatic do_reset();
        PRESETn = 1'b0;
        s_psel = 0; s_penable = 0;
        repeat (3) @(posedge PCLK);
        log_q.delete();
        @(negedge PCLK);
        PRESETn = 1'b1;
    endtask

    task automatic wait_boot(input string tag, input int budget);
        bit hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge PCLK);
            if (boot_done || boot_err) begin
                hit = 1'b1;
                break;
            end
        end
        chk(tag, hit, 1'b1);
    endtask

    int early_rdy;
    int stall_cyc;

    task automatic apb_xfer(input logic wr, input logic [3:0] addr, input logic [31:0] data,
                            output logic [31:0] rdata, output logic slverr);
        bit got = 1'b0;
        rdata = 32'h0; slverr = 1'b0; stall_cyc = 0;
        @(posedge PCLK); #1;
        s_psel = 1; s_penable = 0; s_pwrite = wr; s_paddr = addr; s_pwdata = data;
        s_pstrb = 4'hF; s_pprot = 3'b001;
        @(posedge PCLK); #1;
        s_penable = 1;
        for (int i = 0; i < 300; i++) begin
            @(negedge PCLK);
            if (s_pready) begin
                if (!(boot_done || boot_err)) early_rdy++;
                rdata = s_prdata; slverr = s_pslverr; got = 1'b1;
                break;
            end
            stall_cyc++;
        end
        chk("apb_xfer_completes", got, 1'b1);
        @(posedge PCLK); #1;
        s_psel = 0; s_penable = 0;
    endtask

    logic [31:0] rd;
    logic        se;
    int          nrd, nrd0, nwr0;

    initial begin
        // Test 1: reset state, then full boot with wait states and ignored early PSLVERR
        PRESETn = 1'b0;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        chk("rst_m_psel", m_psel, 1'b0);
        chk("rst_m_penable", m_penable, 1'b0);
        chk("rst_done", boot_done, 1'b0);
        chk("rst_err", boot_err, 1'b0);
        ws = 1; junk_err = 1; err_en = 0; init_dly = 12;
        do_reset();
        wait_boot("t1_boot_ends", 200);
        chk("t1_done", boot_done, 1'b1);
        chk("t1_err", boot_err, 1'b0);
        chk("t1_x0", {log_at(0).wr, log_at(0).addr, log_at(0).dat}, {1'b1, 4'h4, 32'h1234_5678});
        chk("t1_x0_strb_prot", {log_at(0).strb, log_at(0).prot}, {4'hF, 3'b001});
        chk("t1_x1", {log_at(1).wr, log_at(1).addr, log_at(1).dat}, {1'b1, 4'h8, 32'h0000_00C8});
        nrd = log_q.size() - 3;
        chk("t1_polled_at_least_twice", (nrd >= 2), 1'b1);
        nrd0 = 0;
        for (int k = 2; k < log_q.size() - 1; k++)
            if (!log_q[k].wr && log_q[k].addr == 4'h0 && !log_q[k].dat[30]) nrd0++;
        chk("t1_polls_before_ready", nrd0, nrd - 1);
        chk("t1_last_poll_ready", log_at(log_q.size() - 2).dat[30], 1'b1);
        chk("t1_ctrl_write", {log_at(log_q.size() - 1).wr, log_at(log_q.size() - 1).addr,
                              log_at(log_q.size() - 1).dat}, {1'b1, 4'h0, 32'h8000_0011});
        chk("t1_csr_ctrl", csr_ctrl, 32'h8000_0011);

        // Test 2: upstream write stalled through boot, then given a fresh setup phase
        init_dly = 12; early_rdy = 0;
        do_reset();
        fork
            apb_xfer(1'b1, 4'h4, 32'h0000_A5A5, rd, se);
            begin
                bit seen = 1'b0;
                for (int i = 0; i < 300; i++) begin
                    @(negedge PCLK);
                    if (boot_done) begin seen = 1'b1; break; end
                end
                chk("t2_boot_done", seen, 1'b1);
                chk("t2_handover_setup", {m_psel, m_penable, m_pwrite, m_paddr, s_pready},
                    {1'b1, 1'b0, 1'b1, 4'h4, 1'b0});
                @(negedge PCLK);
                chk("t2_passthru_access", {m_psel, m_penable, m_pwdata}, {1'b1, 1'b1, 32'h0000_A5A5});
            end
        join
        chk("t2_no_early_ready", early_rdy, 0);
        chk("t2_stalled_long", (stall_cyc > 10), 1'b1);
        apb_xfer(1'b0, 4'h4, 32'h0, rd, se);
        chk("t2_readback", {se, rd}, {1'b0, 32'h0000_A5A5});

        // Test 3: PSLVERR on TREF write aborts the sequence
        err_en = 1; err_addr = 4'h8; init_dly = 12;
        do_reset();
        wait_boot("t3_boot_ends", 200);
        chk("t3_flags", {boot_err, boot_done}, {1'b1, 1'b0});
        chk("t3_log_len", log_q.size(), 2);
        chk("t3_x1_addr", log_at(1).addr, 4'h8);
        s_psel = 1; s_penable = 0; s_pwrite = 0; s_paddr = 4'h4;
        #1;
        chk("t3_handover", {m_psel, m_penable, s_pready}, {1'b1, 1'b0, 1'b0});
        @(posedge PCLK); #1;
        s_penable = 1;
        @(negedge PCLK);
        chk("t3_passthru_enable", m_penable, 1'b1);
        @(negedge PCLK);
        chk("t3_passthru_read", {s_pready, s_pslverr, s_prdata}, {1'b1, 1'b0, 32'h1234_5678});
        @(posedge PCLK); #1;
        s_psel = 0; s_penable = 0; err_en = 0;

        // Test 4: init_done never rises -> exactly POLL_MAX reads then error
        init_dly = 1_000_000;
        do_reset();
        wait_boot("t4_boot_ends", 300);
        chk("t4_flags", {boot_err, boot_done}, {1'b1, 1'b0});
        nrd0 = 0; nwr0 = 0;
        for (int k = 0; k < log_q.size(); k++) begin
            if (log_q[k].addr == 4'h0 && !log_q[k].wr) nrd0++;
            if (log_q[k].addr == 4'h0 && log_q[k].wr) nwr0++;
        end
        chk("t4_poll_reads", nrd0, 8);
        chk("t4_no_ctrl_write", nwr0, 0);

        // Test 5: reset during poll ACCESS aborts and restarts
        init_dly = 1000;
        do_reset();
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge PCLK);
                if (m_psel && m_penable && !m_pwrite && m_paddr == 4'h0) begin hit = 1'b1; break; end
            end
            chk("t5_reached_poll", hit, 1'b1);
        end
        #2 PRESETn = 1'b0;
        #1;
        chk("t5_async_psel", m_psel, 1'b0);
        init_dly = 12;
        do_reset();
        wait_boot("t5_boot_ends", 200);
        chk("t5_done", {boot_done, boot_err}, {1'b1, 1'b0});
        chk("t5_restart_x0", {log_at(0).wr, log_at(0).addr, log_at(0).dat}, {1'b1, 4'h4, 32'h1234_5678});
        chk("t5_csr_ctrl", csr_ctrl, 32'h8000_0011);

        // Test 6: BOOT_EN=0 instance is a wire
        for (int v = 0; v < 8; v++) begin
            @(negedge PCLK);
            {p_s_psel, p_s_penable, p_s_pwrite} = 3'($urandom);
            p_s_paddr = 4'($urandom); p_s_pwdata = $urandom;
            p_s_pstrb = 4'($urandom); p_s_pprot = 3'($urandom);
            p_m_prdata = $urandom; {p_m_pready, p_m_pslverr} = 2'($urandom);
            #1;
            chk("t6_m_side", {p_m_psel, p_m_penable, p_m_pwrite, p_m_paddr, p_m_pwdata, p_m_pstrb, p_m_pprot},
                {p_s_psel, p_s_penable, p_s_pwrite, p_s_paddr, p_s_pwdata, p_s_pstrb, p_s_pprot});
            chk("t6_s_side", {p_s_prdata, p_s_pready, p_s_pslverr}, {p_m_prdata, p_m_pready, p_m_pslverr});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
